// File: rtl/dbg_trace_pkg.sv
// Shared record type and constants for the debug trace arbiter.
// Optional build macro: DBG_TRACE_TIMESTAMP_EN adds a push-time cycle stamp to each record.
package dbg_trace_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_HEX_W  = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int REG_DATA_W  = 64;
    localparam int TIMESTAMP_W = 32;

    typedef struct packed {
        logic                   inst_valid;
        logic [INST_ADDR_W-1:0] inst_addr;
        logic [INST_HEX_W-1:0]  inst_hex;
        logic                   reg_wren;
        logic [REG_ADDR_W-1:0]  reg_wraddr;
        logic [REG_DATA_W-1:0]  reg_wrdata;
`ifdef DBG_TRACE_TIMESTAMP_EN
        logic [TIMESTAMP_W-1:0] timestamp;
`endif
    } trace_rec_t;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/dbg_trace_fifo.sv
// Per-hart trace record FIFO; full/empty distinguished by an extra pointer bit.
// Optional build macro: DBG_TRACE_TIMESTAMP_EN (widens trace_rec_t only).
module dbg_trace_fifo
    import dbg_trace_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           push,
    input  logic           pop,
    input  trace_rec_t     push_rec,
    output trace_rec_t     head,
    output logic           full,
    output logic           empty,
    output logic [PTR_W:0] count
);

    trace_rec_t     mem [DEPTH];
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    // A full FIFO may still accept a record when its head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[PTR_W-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_rec;
    end

endmodule

// File: rtl/dbg_trace_arbiter.sv
// Round-robin serialiser of per-hart debug trace records onto one monitor stream.
// Optional build macro: DBG_TRACE_TIMESTAMP_EN adds a cycle counter and out_timestamp.
module dbg_trace_arbiter
    import dbg_trace_pkg::*;
#(
    parameter  int NUM_HARTS  = 4,
    parameter  int FIFO_DEPTH = 4,
    parameter  int DROP_CNT_W = 16,
    localparam int HID_W      = $clog2(NUM_HARTS)
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [NUM_HARTS-1:0]            in_valid,
    input  logic [NUM_HARTS-1:0]            in_inst_valid,
    input  logic [NUM_HARTS*32-1:0]         in_inst_addr,
    input  logic [NUM_HARTS*32-1:0]         in_inst_hex,
    input  logic [NUM_HARTS-1:0]            in_reg_wren,
    input  logic [NUM_HARTS*5-1:0]          in_reg_wraddr,
    input  logic [NUM_HARTS*64-1:0]         in_reg_wrdata,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [HID_W-1:0]                out_hart_id,
    output logic                            out_inst_valid,
    output logic [31:0]                     out_inst_addr,
    output logic [31:0]                     out_inst_hex,
    output logic                            out_reg_wren,
    output logic [4:0]                      out_reg_wraddr,
    output logic [63:0]                     out_reg_wrdata,
    output logic [NUM_HARTS*DROP_CNT_W-1:0] drop_cnt,
    output logic [NUM_HARTS-1:0]            overflow
`ifdef DBG_TRACE_TIMESTAMP_EN
    ,
    output logic [31:0]                     out_timestamp
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    trace_rec_t             head [NUM_HARTS];
    trace_rec_t             out_rec;
    logic [NUM_HARTS-1:0]   next_nonempty;
    arb_state_t             state;
    logic [HID_W-1:0]       grant_id;
    logic [HID_W-1:0]       rr_ptr;
    logic [HID_W-1:0]       rr_base;
    logic [HID_W-1:0]       pick_id;
    logic                   pick_found;
    logic                   advance;
    logic                   pop_any;

`ifdef DBG_TRACE_TIMESTAMP_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cycle_cnt <= '0;
        else          cycle_cnt <= cycle_cnt + 1'b1;
    end
`endif

    // Re-arbitration happens when idle or when the granted record is accepted.
    assign advance = (state == ARB_IDLE) || out_ready;
    assign pop_any = (state == ARB_GRANT) && out_ready;
    assign rr_base = pop_any ? grant_id : rr_ptr;

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        trace_rec_t             rec;
        trace_rec_t             head_h;
        logic                   full_h;
        logic                   empty_h;
        logic                   push_h;
        logic                   pop_h;
        logic                   drop_h;
        logic [CNT_W-1:0]       cnt_h;
        logic [DROP_CNT_W-1:0]  drop_q;
        logic                   ovf_q;

        // NOTE: default every always_comb output first so no path can infer a latch.
        always_comb begin
            rec            = '0;
            rec.inst_valid = in_inst_valid[h];
            rec.inst_addr  = in_inst_addr[32*h +: 32];
            rec.inst_hex   = in_inst_hex[32*h +: 32];
            rec.reg_wren   = in_reg_wren[h];
            rec.reg_wraddr = in_reg_wraddr[5*h +: 5];
            rec.reg_wrdata = in_reg_wrdata[64*h +: 64];
`ifdef DBG_TRACE_TIMESTAMP_EN
            rec.timestamp  = cycle_cnt;
`endif
        end

        assign pop_h  = pop_any && (grant_id == HID_W'(h)) && !empty_h;
        assign push_h = in_valid[h] && (!full_h || pop_h);
        assign drop_h = in_valid[h] && full_h && !pop_h;
        // Occupancy after this edge, so a record pushed now can be granted now.
        assign next_nonempty[h] = push_h || (cnt_h > CNT_W'(pop_h));

        dbg_trace_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clock    (clock),
            .reset_n  (reset_n),
            .push     (push_h),
            .pop      (pop_h),
            .push_rec (rec),
            .head     (head_h),
            .full     (full_h),
            .empty    (empty_h),
            .count    (cnt_h)
        );

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                drop_q <= '0;
                ovf_q  <= 1'b0;
            end else if (drop_h) begin
                if (drop_q != '1) drop_q <= drop_q + 1'b1;
                ovf_q <= 1'b1;
            end
        end

        assign head[h]                               = head_h;
        assign drop_cnt[h*DROP_CNT_W +: DROP_CNT_W] = drop_q;
        assign overflow[h]                           = ovf_q;
    end

    always_comb begin
        int               idx;
        logic [HID_W-1:0] idx_h;
        idx        = 0;
        idx_h      = '0;
        pick_found = 1'b0;
        pick_id    = '0;
        for (int off = 1; off <= NUM_HARTS; off++) begin
            idx   = (int'(rr_base) + off) % NUM_HARTS;
            idx_h = HID_W'(idx);
            if (!pick_found && next_nonempty[idx_h]) begin
                pick_found = 1'b1;
                pick_id    = idx_h;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ARB_IDLE;
            out_valid <= 1'b0;
            grant_id  <= '0;
            rr_ptr    <= HID_W'(NUM_HARTS - 1);
        end else if (advance) begin
            if (pop_any) rr_ptr <= grant_id;
            if (pick_found) begin
                state     <= ARB_GRANT;
                out_valid <= 1'b1;
                grant_id  <= pick_id;
            end else begin
                state     <= ARB_IDLE;
                out_valid <= 1'b0;
            end
        end
    end

    // Record fields follow the FIFO head of the registered grant and read zero when idle.
    assign out_rec        = out_valid ? head[grant_id] : '0;
    assign out_hart_id    = out_valid ? grant_id : '0;
    assign out_inst_valid = out_rec.inst_valid;
    assign out_inst_addr  = out_rec.inst_addr;
    assign out_inst_hex   = out_rec.inst_hex;
    assign out_reg_wren   = out_rec.reg_wren;
    assign out_reg_wraddr = out_rec.reg_wraddr;
    assign out_reg_wrdata = out_rec.reg_wrdata;
`ifdef DBG_TRACE_TIMESTAMP_EN
    assign out_timestamp  = out_rec.timestamp;
`endif

endmodule

// File: tb/tb_dbg_trace_arbiter.sv
// Self-checking bench for dbg_trace_arbiter against a queue-based reference model.
// Built with DBG_TRACE_TIMESTAMP_EN undefined.
`timescale 1ns/1ps
module tb_dbg_trace_arbiter;

    localparam int NH    = 4;
    localparam int DEPTH = 4;
    localparam int DW    = 16;

    typedef struct packed {
        logic        iv;
        logic [31:0] addr;
        logic [31:0] hex;
        logic        wren;
        logic [4:0]  wa;
        logic [63:0] wd;
    } rec_t;

    logic              clock;
    logic              reset_n;
    logic [NH-1:0]     in_valid;
    logic [NH-1:0]     in_inst_valid;
    logic [NH*32-1:0]  in_inst_addr;
    logic [NH*32-1:0]  in_inst_hex;
    logic [NH-1:0]     in_reg_wren;
    logic [NH*5-1:0]   in_reg_wraddr;
    logic [NH*64-1:0]  in_reg_wrdata;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_hart_id;
    logic              out_inst_valid;
    logic [31:0]       out_inst_addr;
    logic [31:0]       out_inst_hex;
    logic              out_reg_wren;
    logic [4:0]        out_reg_wraddr;
    logic [63:0]       out_reg_wrdata;
    logic [NH*DW-1:0]  drop_cnt;
    logic [NH-1:0]     overflow;

    dbg_trace_arbiter #(.NUM_HARTS(NH), .FIFO_DEPTH(DEPTH), .DROP_CNT_W(DW)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_inst_valid  (in_inst_valid),
        .in_inst_addr   (in_inst_addr),
        .in_inst_hex    (in_inst_hex),
        .in_reg_wren    (in_reg_wren),
        .in_reg_wraddr  (in_reg_wraddr),
        .in_reg_wrdata  (in_reg_wrdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_hart_id    (out_hart_id),
        .out_inst_valid (out_inst_valid),
        .out_inst_addr  (out_inst_addr),
        .out_inst_hex   (out_inst_hex),
        .out_reg_wren   (out_reg_wren),
        .out_reg_wraddr (out_reg_wraddr),
        .out_reg_wrdata (out_reg_wrdata),
        .drop_cnt       (drop_cnt),
        .overflow       (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   vectors     = 0;
    int   miscompares = 0;

    rec_t stim [NH];
    rec_t mq [NH][$];
    bit   m_granted;
    int   m_gid;
    int   m_rr;
    int   m_drop [NH];
    bit   m_ovf [NH];

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic rec_t obs_rec();
        return {out_inst_valid, out_inst_addr, out_inst_hex, out_reg_wren, out_reg_wraddr, out_reg_wrdata};
    endfunction

    task automatic rand_stim();
        for (int h = 0; h < NH; h++) begin
            stim[h].iv   = 1'($urandom_range(0, 1));
            stim[h].addr = $urandom;
            stim[h].hex  = $urandom;
            stim[h].wren = 1'($urandom_range(0, 1));
            stim[h].wa   = 5'($urandom);
            stim[h].wd   = {$urandom, $urandom};
        end
    endtask

    task automatic model_clear();
        for (int h = 0; h < NH; h++) begin
            mq[h].delete();
            m_drop[h] = 0;
            m_ovf[h]  = 1'b0;
        end
        m_granted = 1'b0;
        m_gid     = 0;
        m_rr      = NH - 1;
    endtask

    // One clock edge of the arbiter, stated as queue operations.
    task automatic model_edge(input logic [NH-1:0] v, input logic rdy);
        if (m_granted && rdy) begin
            void'(mq[m_gid].pop_front());
            m_rr = m_gid;
        end
        for (int h = 0; h < NH; h++) begin
            if (v[h]) begin
                if (mq[h].size() < DEPTH) begin
                    mq[h].push_back(stim[h]);
                end else begin
                    if (m_drop[h] < (1 << DW) - 1) m_drop[h]++;
                    m_ovf[h] = 1'b1;
                end
            end
        end
        if (!m_granted || rdy) begin
            m_granted = 1'b0;
            for (int off = 1; off <= NH; off++) begin
                int idx;
                idx = (m_rr + off) % NH;
                if (!m_granted && mq[idx].size() > 0) begin
                    m_granted = 1'b1;
                    m_gid     = idx;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("out_valid", 192'(out_valid), 192'(m_granted));
        if (m_granted) begin
            check("out_hart_id", 192'(out_hart_id), 192'(m_gid));
            check("out_record", 192'(obs_rec()), 192'(mq[m_gid][0]));
        end
        for (int h = 0; h < NH; h++) begin
            check($sformatf("drop_cnt[%0d]", h), 192'(drop_cnt[DW*h +: DW]), 192'(m_drop[h]));
            check($sformatf("overflow[%0d]", h), 192'(overflow[h]), 192'(m_ovf[h]));
        end
    endtask

    task automatic step(input logic [NH-1:0] v, input logic rdy);
        for (int h = 0; h < NH; h++) begin
            in_inst_valid[h]          = stim[h].iv;
            in_inst_addr[32*h +: 32]  = stim[h].addr;
            in_inst_hex[32*h +: 32]   = stim[h].hex;
            in_reg_wren[h]            = stim[h].wren;
            in_reg_wraddr[5*h +: 5]   = stim[h].wa;
            in_reg_wrdata[64*h +: 64] = stim[h].wd;
        end
        in_valid  = v;
        out_ready = rdy;
        @(posedge clock);
        model_edge(v, rdy);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        in_valid  = '0;
        out_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        model_clear();
        check("rst_out_valid", 192'(out_valid), 192'(0));
        check("rst_hart_id", 192'(out_hart_id), 192'(0));
        check("rst_record", 192'(obs_rec()), 192'(0));
        check("rst_drop_cnt", 192'(drop_cnt), 192'(0));
        check("rst_overflow", 192'(overflow), 192'(0));
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
        @(posedge clock);
        #1;
        compare_all();
    endtask

    initial begin
        reset_n       = 1'b1;
        in_valid      = '0;
        out_ready     = 1'b0;
        in_inst_valid = '0;
        in_inst_addr  = '0;
        in_inst_hex   = '0;
        in_reg_wren   = '0;
        in_reg_wraddr = '0;
        in_reg_wrdata = '0;
        model_clear();
        @(posedge clock);
        #1;

        // Single record from hart 2.
        do_reset();
        rand_stim();
        stim[2].addr = 32'h8000_0010;
        step(4'b0100, 1'b1);
        check("single_hart_id", 192'(out_hart_id), 192'(2));
        check("single_pc", 192'(out_inst_addr), 192'(32'h8000_0010));
        rand_stim();
        step(4'b0000, 1'b1);
        check("single_done", 192'(out_valid), 192'(0));

        // Two bursts from all harts drain in hart order.
        do_reset();
        for (int b = 0; b < 2; b++) begin
            rand_stim();
            step(4'b1111, 1'b1);
            check("burst_first", 192'(out_hart_id), 192'(0));
            for (int k = 1; k < NH; k++) begin
                rand_stim();
                step(4'b0000, 1'b1);
                check($sformatf("burst_order_%0d", k), 192'(out_hart_id), 192'(k));
            end
            rand_stim();
            step(4'b0000, 1'b1);
        end

        // Stall holds hart 1 while hart 0 queues behind it.
        do_reset();
        rand_stim();
        step(4'b0010, 1'b0);
        for (int c = 0; c < 10; c++) begin
            rand_stim();
            step((c < 3) ? 4'b0001 : 4'b0000, 1'b0);
            check("stall_hold", 192'(out_hart_id), 192'(1));
        end
        rand_stim();
        step(4'b0000, 1'b1);
        check("stall_next", 192'(out_hart_id), 192'(0));
        repeat (4) begin
            rand_stim();
            step(4'b0000, 1'b1);
        end

        // Overflow on hart 3: six pushes into four entries.
        do_reset();
        repeat (6) begin
            rand_stim();
            step(4'b1000, 1'b0);
        end
        check("drop_two", 192'(drop_cnt[3*DW +: DW]), 192'(2));
        check("ovf_set", 192'(overflow[3]), 192'(1));
        repeat (5) begin
            rand_stim();
            step(4'b0000, 1'b1);
        end

        // Full FIFO pushed and popped on the same edge.
        do_reset();
        repeat (4) begin
            rand_stim();
            step(4'b1000, 1'b0);
        end
        rand_stim();
        step(4'b1000, 1'b1);
        check("full_pushpop_nodrop", 192'(drop_cnt[3*DW +: DW]), 192'(0));
        repeat (5) begin
            rand_stim();
            step(4'b0000, 1'b1);
        end

        // Reset while records are queued and one is offered.
        do_reset();
        repeat (3) begin
            rand_stim();
            step(4'b0001, 1'b0);
        end
        #2 reset_n = 1'b0;
        #1;
        model_clear();
        check("midrst_valid", 192'(out_valid), 192'(0));
        check("midrst_drop", 192'(drop_cnt), 192'(0));
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
        repeat (3) begin
            rand_stim();
            step(4'b0000, 1'b1);
        end

        // Random traffic with random back-pressure.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rand_stim();
            step(NH'($urandom), ($urandom_range(0, 9) < 6));
        end
        repeat (20) begin
            rand_stim();
            step(4'b0000, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dbg_trace_arbiter.md
Name: dbg_trace_arbiter

Overview:
Collects per-cycle debug trace records from NUM_HARTS cores and serialises them onto one record stream for the simulation monitor. Each hart has a small FIFO; a round-robin scheduler picks one non-empty FIFO per transfer. Cores are never back-pressured: a record arriving at a full FIFO is dropped and counted. Sits between the core debug ports and the single monitor instance in the SoC testbench top.

Parameters:
NUM_HARTS, 4, number of hart trace inputs (2..8); hart id width HID_W = $clog2(NUM_HARTS).
FIFO_DEPTH, 4, entries per hart FIFO; power of two, >= 2.
DROP_CNT_W, 16, width of per-hart saturating drop counters.

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  NUM_HARTS  per-hart record valid; no ready, push is fire-and-forget
in_inst_valid  in  NUM_HARTS  per-hart instruction-retired flag
in_inst_addr  in  NUM_HARTS*32  per-hart PC, hart h at [32h+31:32h]
in_inst_hex  in  NUM_HARTS*32  per-hart instruction word
in_reg_wren  in  NUM_HARTS  per-hart register write enable
in_reg_wraddr  in  NUM_HARTS*5  per-hart destination register
in_reg_wrdata  in  NUM_HARTS*64  per-hart write data
out_valid  out  1  record available
out_ready  in  1  monitor accepts record
out_hart_id  out  HID_W  source hart of out record
out_inst_valid  out  1  record field
out_inst_addr  out  32  record field
out_inst_hex  out  32  record field
out_reg_wren  out  1  record field
out_reg_wraddr  out  5  record field
out_reg_wrdata  out  64  record field
drop_cnt  out  NUM_HARTS*DROP_CNT_W  per-hart dropped-record counters
overflow  out  NUM_HARTS  sticky per-hart flag, set on first drop

Behaviour:
- Reset (async assert, sync-safe deassert): all FIFOs empty, out_valid=0, out_* record fields=0, out_hart_id=0, drop_cnt=0, overflow=0, RR pointer=NUM_HARTS-1 (hart 0 wins first).
- Push: in_valid[h]=1 and FIFO h not full -> record written at clock edge. Full and simultaneously popped -> push accepted (count unchanged). Full and not popped -> record dropped, drop_cnt[h] += 1 saturating at all-ones, overflow[h] set until reset.
- Latency: record pushed at edge N visible at out at earliest after edge N (same cycle as first out_valid=1); no combinational in->out path.
- Arbiter states: IDLE (no grant) / GRANT(h). IDLE -> GRANT(h) when any FIFO non-empty; h = first non-empty hart scanning from RR pointer+1, wrapping modulo NUM_HARTS.
- GRANT(h): out_valid=1, out_* = head of FIFO h, out_hart_id=h. Grant held stable while out_valid && !out_ready (no switching, record fields stable). On out_ready: pop FIFO h, RR pointer=h, re-arbitrate next cycle (next grant may follow immediately, one record per cycle sustained).
- Only hart with grant pops; single pop per cycle.
- FIFO pointers wrap modulo FIFO_DEPTH; full/empty distinguished by extra pointer bit.
- Reset mid-transfer: all in-flight and queued records discarded.

Optional Feature:
DBG_TRACE_TIMESTAMP_EN: adds free-running 32-bit cycle counter (reset 0, wraps) and output out_timestamp (32). Timestamp captured into FIFO entry at push; out_timestamp = cycle of push. Without macro: no counter, no port, FIFO entry omits field.

Decomposition:
- Package dbg_trace_pkg: typedef struct packed trace_rec_t {inst_valid, inst_addr, inst_hex, reg_wren, reg_wraddr, reg_wrdata[, timestamp]}; constants for field widths.
- Sub-module dbg_trace_fifo: one FIFO of trace_rec_t with push/pop/full/empty; instantiated NUM_HARTS times via generate.
- Arbiter, RR pointer, drop counters in top.

Test Plan:
- Single push hart 2, PC=0x80000010, out_ready=1 -> next cycle out_valid=1, out_hart_id=2, out_inst_addr=0x80000010, then out_valid=0.
- All 4 harts push one record same cycle, out_ready=1 -> outputs in hart order 0,1,2,3 on consecutive cycles; second burst after hart 3 grant -> order 0,1,2,3 again.
- out_ready=0 for 10 cycles with hart 1 pending, hart 0 pushing -> out_hart_id stays 1, fields unchanged; on ready, hart 1 popped then hart 0 next.
- Hart 3 pushes 6 records, out_ready=0, FIFO_DEPTH=4 -> drop_cnt[3]=2, overflow[3]=1; draining yields first 4 records in order.
- Full FIFO with push and pop same cycle -> no drop, count stays 4, new record last out.
- reset_n low while 3 records queued and out_valid=1 -> out_valid=0 immediately, counters 0, no stale records after release.
